// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// ============================================================================
// clk_period_meter
//
// Purpose:
//   Measures a slow, asynchronous square wave in units of i_clk_in cycles.
//   The input is synchronised into the i_clk_in domain and edge-detected.
//   A small FSM then times the high phase and the full period between
//   consecutive rising edges. Each complete measurement is reported with a
//   single-cycle o_meas_valid pulse. If no edge arrives within TIMEOUT
//   cycles, o_timeout is raised and the FSM waits for a fresh rising edge.
//
// Parameters:
//   SRC_FREQ    - i_clk_in frequency in Hz
//   MIN_FREQ    - lowest measurable input frequency in Hz
//   SYNC_STAGES - depth of the input synchroniser (2 or more)
//   TIMEOUT     - SRC_FREQ / MIN_FREQ, the loss-of-signal limit in cycles
//   W           - bits needed to hold TIMEOUT
//
// Ports:
//   i_clk_in     - system clock
//   i_rst        - asynchronous reset, active high
//   i_sig_in     - asynchronous signal to measure
//   o_sig_sync   - synchronised copy of i_sig_in (last synchroniser stage)
//   o_sig_rise   - one-cycle pulse per synchronised rising edge
//   o_period     - last measured period in i_clk_in cycles
//   o_high_time  - high time belonging to the same measurement as o_period
//   o_meas_valid - one-cycle pulse when o_period / o_high_time update
//   o_timeout    - level; no edge seen within TIMEOUT cycles
// ============================================================================
module clk_period_meter #(
   parameter int SRC_FREQ    = 100_000_000,
   parameter int MIN_FREQ    = 10,
   parameter int SYNC_STAGES = 2,
   localparam int TIMEOUT    = SRC_FREQ / MIN_FREQ,
   localparam int W          = $clog2(TIMEOUT + 1)
) (
   input  logic         i_clk_in,
   input  logic         i_rst,
   input  logic         i_sig_in,
   output logic         o_sig_sync,
   output logic         o_sig_rise,
   output logic [W-1:0] o_period,
   output logic [W-1:0] o_high_time,
   output logic         o_meas_valid,
   output logic         o_timeout
);

   localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);
   localparam logic [W-1:0] ONE_CNT     = W'(1);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sigPrev;
   logic                   r_sigRise;

   state_t                 r_state;
   logic [W-1:0]           r_cnt;
   logic [W-1:0]           r_highCap;
   logic [W-1:0]           r_period;
   logic [W-1:0]           r_highTime;
   logic                   r_measValid;
   logic                   r_timeout;

   logic                   w_sigSync;
   logic                   w_rise;
   logic                   w_fall;
   logic [W-1:0]           w_elapsed;

   // The last synchroniser stage is the only safe view of the input; edges
   // are found by comparing it against its own one-cycle-delayed copy.
   assign w_sigSync = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_sigSync & ~r_sigPrev;
   assign w_fall    = ~w_sigSync & r_sigPrev;

   // In LOW the counter restarted at the fall, so the time since the last
   // rise is the captured high time plus the low-phase count. This sum is
   // bounded by TIMEOUT, so it never wraps in W bits.
   assign w_elapsed = r_highCap + r_cnt;

   // Input synchroniser, delayed copy for edge detection, and the registered
   // rise pulse. The shift register pulls i_sig_in in at bit 0.
   always_ff @(posedge i_clk_in or posedge i_rst) begin
      if (i_rst) begin
         r_sync    <= '0;
         r_sigPrev <= 1'b0;
         r_sigRise <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
         r_sigPrev <= w_sigSync;
         r_sigRise <= w_rise;
      end
   end

   // Measurement FSM. The counter is loaded with 1 on every edge it acts on,
   // so reading it on the next edge gives the exact number of cycles between
   // the two edge detections. An edge always beats the timeout check, which
   // lets a period of exactly TIMEOUT still be reported. The very first rise
   // after reset or timeout only arms the FSM and never yields a result.
   always_ff @(posedge i_clk_in or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_highCap   <= '0;
         r_period    <= '0;
         r_highTime  <= '0;
         r_measValid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_measValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_cnt   <= ONE_CNT;
                  r_state <= HIGH;
               end else begin
                  r_cnt   <= '0;
               end
            end

            HIGH: begin
               if (w_fall) begin
                  r_highCap <= r_cnt;
                  r_cnt     <= ONE_CNT;
                  r_state   <= LOW;
               end else if (r_cnt == TIMEOUT_CNT) begin
                  r_timeout <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt     <= r_cnt + ONE_CNT;
               end
            end

            LOW: begin
               if (w_rise) begin
                  r_period    <= w_elapsed;
                  r_highTime  <= r_highCap;
                  r_measValid <= 1'b1;
                  r_timeout   <= 1'b0;
                  r_cnt       <= ONE_CNT;
                  r_state     <= HIGH;
               end else if (w_elapsed == TIMEOUT_CNT) begin
                  r_timeout   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= IDLE;
               end else begin
                  r_cnt       <= r_cnt + ONE_CNT;
               end
            end

            default: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_sig_sync   = w_sigSync;
   assign o_sig_rise   = r_sigRise;
   assign o_period     = r_period;
   assign o_high_time  = r_highTime;
   assign o_meas_valid = r_measValid;
   assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
// ============================================================================
// tb_clk_period_meter
//
// Directed bench for clk_period_meter with SRC_FREQ=1000, MIN_FREQ=10, so
// TIMEOUT=100 and W=7. The stimulus process keeps a small behavioural model
// of which rising edges complete a measurement and pushes the expected
// period / high time into a scoreboard queue when it drives that rise. A
// separate monitor pops the queue on every o_meas_valid and compares.
// ============================================================================
module tb_clk_period_meter;

   localparam int SRC_FREQ    = 1000;
   localparam int MIN_FREQ    = 10;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = SRC_FREQ / MIN_FREQ;
   localparam int W           = 7;

   typedef struct {
      int period;
      int highTime;
      int tol;
      bit gapCheck;
   } expect_t;

   logic         clk;
   logic         rst;
   logic         sigIn;
   logic         sigSync;
   logic         sigRise;
   logic [W-1:0] period;
   logic [W-1:0] highTime;
   logic         measValid;
   logic         timeoutFlag;

   expect_t      sbQueue[$];
   int           testCount = 0;
   int           failCount = 0;
   int           cycleCount = 0;
   int           lastMeasCycle = 0;

   // Model state: the previous full period driven and whether it was
   // short enough to be completed by the next rise.
   bit           mHaveFull = 0;
   bit           mPrevPushed = 0;
   int           mHigh = 0;
   int           mLow = 0;

   clk_period_meter #(
      .SRC_FREQ    (SRC_FREQ),
      .MIN_FREQ    (MIN_FREQ),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .i_clk_in     (clk),
      .i_rst        (rst),
      .i_sig_in     (sigIn),
      .o_sig_sync   (sigSync),
      .o_sig_rise   (sigRise),
      .o_period     (period),
      .o_high_time  (highTime),
      .o_meas_valid (measValid),
      .o_timeout    (timeoutFlag)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle index used to measure spacing between results.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
      testCount++;
      assert (observed >= lo && observed <= hi) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive a rise; if the previous full period can be completed by it,
   // queue the expected measurement.
   task automatic riseEdge();
      bit pushed;
      pushed = mHaveFull;
      if (pushed) begin
         sbQueue.push_back('{period: mHigh + mLow, highTime: mHigh, tol: 0,
                             gapCheck: mPrevPushed});
      end
      mPrevPushed = pushed;
      sigIn = 1'b1;
   endtask

   // One full period synchronous to the clock: high for 'high' edges, then
   // low for 'low' edges. Optionally checks synchroniser / rise latency.
   task automatic applyStimulus(input int high, input int low, input bit checkRise);
      riseEdge();
      for (int i = 1; i <= high; i++) begin
         waitCycle();
         if (checkRise) begin
            if (i == 1) checkOutput("sync_e1", int'(sigSync), 0);
            if (i == 2) checkOutput("sync_e2", int'(sigSync), 1);
            if (i == 2) checkOutput("rise_e2", int'(sigRise), 0);
            if (i == 3) checkOutput("rise_e3", int'(sigRise), 1);
            if (i == 4) checkOutput("rise_e4", int'(sigRise), 0);
         end
      end
      sigIn = 1'b0;
      repeat (low) waitCycle();
      mHigh     = high;
      mLow      = low;
      mHaveFull = (high + low <= TIMEOUT);
   endtask

   task automatic modelReset();
      mHaveFull   = 0;
      mPrevPushed = 0;
   endtask

   // Scoreboard consumer: every result pulse must match the oldest entry.
   always @(negedge clk) begin
      expect_t e;
      if (!rst && measValid) begin
         checkOutput("meas_expected", int'(sbQueue.size() > 0), 1);
         if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkRange("period", int'(period), e.period - e.tol, e.period + e.tol);
            checkRange("high_time", int'(highTime), e.highTime - e.tol, e.highTime + e.tol);
            checkOutput("timeout_on_meas", int'(timeoutFlag), 0);
            if (e.gapCheck) checkOutput("meas_gap", cycleCount - lastMeasCycle, e.period);
         end
         lastMeasCycle <= cycleCount;
      end
   end

   // Global guard so the run always ends even if something stalls.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      sigIn = 1'b0;
      repeat (3) waitCycle();
      checkOutput("rst_sig_sync", int'(sigSync), 0);
      checkOutput("rst_sig_rise", int'(sigRise), 0);
      checkOutput("rst_period", int'(period), 0);
      checkOutput("rst_high_time", int'(highTime), 0);
      checkOutput("rst_meas_valid", int'(measValid), 0);
      checkOutput("rst_timeout", int'(timeoutFlag), 0);
      rst = 1'b0;
      repeat (2) waitCycle();

      $display("[TB] 20/20 toggling");
      for (int n = 0; n < 5; n++) begin
         applyStimulus(20, 20, 1'b0);
         checkOutput("s1_timeout", int'(timeoutFlag), 0);
      end

      $display("[TB] 7/33 duty and rise latency");
      applyStimulus(7, 33, 1'b1);
      applyStimulus(7, 33, 1'b0);
      applyStimulus(7, 33, 1'b0);
      applyStimulus(20, 20, 1'b0);

      $display("[TB] loss of signal");
      riseEdge();
      for (int k = 1; k <= 120; k++) begin
         waitCycle();
         if (k == 20) sigIn = 1'b0;
         if (k == 102) checkOutput("s3_timeout_k102", int'(timeoutFlag), 0);
         if (k == 103) checkOutput("s3_timeout_k103", int'(timeoutFlag), 1);
      end
      modelReset();
      checkOutput("s3_period_hold", int'(period), 40);
      checkOutput("s3_high_hold", int'(highTime), 20);
      applyStimulus(20, 20, 1'b0);
      checkOutput("s3_timeout_first_rise", int'(timeoutFlag), 1);
      applyStimulus(20, 20, 1'b0);
      checkOutput("s3_timeout_cleared", int'(timeoutFlag), 0);

      $display("[TB] period at the timeout boundary");
      applyStimulus(50, 50, 1'b0);
      applyStimulus(50, 50, 1'b0);
      checkOutput("s4_timeout_100", int'(timeoutFlag), 0);
      applyStimulus(50, 51, 1'b0);
      applyStimulus(50, 50, 1'b0);
      checkOutput("s4_timeout_101", int'(timeoutFlag), 1);
      checkOutput("s4_period_hold", int'(period), 100);
      applyStimulus(50, 50, 1'b0);
      checkOutput("s4_timeout_recover", int'(timeoutFlag), 0);

      $display("[TB] asynchronous reset mid-LOW");
      applyStimulus(20, 20, 1'b0);
      applyStimulus(10, 10, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("s5_sig_sync", int'(sigSync), 0);
      checkOutput("s5_sig_rise", int'(sigRise), 0);
      checkOutput("s5_period", int'(period), 0);
      checkOutput("s5_high_time", int'(highTime), 0);
      checkOutput("s5_meas_valid", int'(measValid), 0);
      checkOutput("s5_timeout", int'(timeoutFlag), 0);
      #7;
      rst = 1'b0;
      modelReset();
      waitCycle();
      applyStimulus(20, 20, 1'b0);
      applyStimulus(20, 20, 1'b0);
      applyStimulus(20, 20, 1'b0);

      $display("[TB] asynchronous 30/30 input");
      repeat (110) waitCycle();
      checkOutput("s6_pre_timeout", int'(timeoutFlag), 1);
      modelReset();
      for (int p = 0; p < 6; p++) begin
         if (p > 0) begin
            sbQueue.push_back('{period: 60, highTime: 30, tol: 1, gapCheck: 1'b0});
         end
         sigIn = 1'b1;
         #300.3;
         sigIn = 1'b0;
         #300.3;
      end
      repeat (150) waitCycle();
      checkOutput("s6_end_timeout", int'(timeoutFlag), 1);

      checkOutput("scoreboard_empty", sbQueue.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Inverse of the clock divider. It takes a slow, asynchronous square wave such as a divided clock or external strobe and measures it in clk_in cycles.
- It synchronises the input into the clk_in domain, then measures the period and high time.
- It reports each complete measurement with a one-cycle valid pulse.
- It flags loss of signal when no edge arrives within the timeout.
- Used to check divided-clock frequencies on hardware and to time slow external signals.

Parameters:
- SRC_FREQ, 100_000_000: clk_in frequency in Hz.
- MIN_FREQ, 10: lowest measurable input frequency in Hz. TIMEOUT = SRC_FREQ / MIN_FREQ cycles.
- SYNC_STAGES, 2: number of flip-flops in the input synchroniser. Must be 2 or more.
- W (localparam): clog2(TIMEOUT), where clog2 is the number of bits needed to store the value. Default TIMEOUT is 10_000_000, so W = 24.

Ports:
- clk_in, input, 1: system clock.
- rst, input, 1: asynchronous reset, active high.
- sig_in, input, 1: asynchronous signal to measure.
- sig_sync, output, 1: synchronised copy of sig_in (last synchroniser stage).
- sig_rise, output, 1: one-cycle pulse on each synchronised rising edge.
- period, output, W: last measured period in clk_in cycles.
- high_time, output, W: high time belonging to the same measurement as period.
- meas_valid, output, 1: one-cycle pulse when period and high_time update.
- timeout, output, 1: level; no edge seen within TIMEOUT cycles.

Behaviour:
- Reset (asynchronous, rst=1): all flops clear immediately.
  - Synchroniser, sig_prev, cnt, period, high_time, captured high time: 0.
  - sig_sync, sig_rise, meas_valid: 0.
  - timeout = 0; state = IDLE.
  - Reset mid-measurement discards any partial measurement.
- Synchroniser and edge detection:
  - sig_in passes through SYNC_STAGES flops; sig_prev is sig_sync delayed by one cycle.
  - rise = sig_sync & ~sig_prev; fall = ~sig_sync & sig_prev. Both are combinational.
  - sig_rise is rise registered, so it is high for exactly one cycle.
- Counter cnt (W bits): loaded with 1 on the cycle an edge is detected, then increments by 1 per cycle. On the N-th cycle after a rise, cnt = N.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: cnt holds 0. A rise sets cnt<=1 and moves to HIGH. Falls are ignored.
  - HIGH: a fall captures high_cap<=cnt, sets cnt<=1 and moves to LOW. Otherwise cnt increments.
  - LOW: a rise does all of the following in that cycle, then moves to HIGH:
    - period<=high_cap+cnt;
    - high_time<=high_cap;
    - meas_valid<=1;
    - timeout<=0;
    - cnt<=1.
  - LOW with no rise: cnt increments.
  - Period equals the number of clk_in cycles between consecutive rise detections.
- Timeout:
  - Applies in HIGH or LOW when the elapsed count reaches TIMEOUT with no edge that cycle.
  - Elapsed count is cnt in HIGH and high_cap+cnt in LOW.
  - Effect: timeout<=1, state<=IDLE, cnt<=0. period and high_time hold their previous values.
  - If an edge and the timeout condition coincide, the edge wins. The measurement is valid, with period up to TIMEOUT.
  - timeout stays high until the next meas_valid or reset.
- Latency: e1 is the first clk_in edge that samples sig_in high. sig_sync rises after edge e(SYNC_STAGES). sig_rise and meas_valid are high in the cycle after edge e(SYNC_STAGES+1).
- The first meas_valid after reset or timeout requires two rises, so the first rise never produces a measurement.
- Glitch rule: a one-cycle high pulse that survives synchronisation is a legal measurement with high_time = 1.
- Widths: high_cap+cnt never exceeds TIMEOUT, so W bits suffice and there is no wrap-around.

Test Plan:
All scenarios use SRC_FREQ=1000 and MIN_FREQ=10, so TIMEOUT=100 and W=7.
1. sig_in toggles every 20 cycles, synchronous to clk_in -> first meas_valid on the second rise. Then period=40 and high_time=20 exactly every 40 cycles; timeout=0 throughout.
2. sig_in high 7 cycles / low 33 cycles -> period=40, high_time=7. sig_rise pulses 1 cycle wide, SYNC_STAGES+1 edges after sig_in goes high.
3. After scenario 1, hold sig_in low -> timeout=1 exactly 100 cycles after the last rise detection; period stays 40. Resume toggling -> timeout clears on the next meas_valid.
4. Period exactly 100 (high 50 / low 50) -> meas_valid with period=100 and timeout never asserted (edge beats timeout). With period 101 -> timeout asserts and no measurement is produced.
5. Assert rst for 1 cycle, asynchronously and mid-LOW -> all outputs are 0 immediately. The next meas_valid comes only after two fresh rises.
6. sig_in driven asynchronously to clk_in (non-integer phase), high 30 / low 30 -> period within 60±1 and high_time within 30±1 every measurement.
